regfile_mp_sb: RTL
==================

Name: regfile_mp_sb

Overview:
- Parametrised multi-port integer register file with write-to-read bypass, per-register busy scoreboard and a sequential clear sweep after reset.
- Sits in the decode stage. Feeds operands to execute and stall information to the hazard unit.
- Writes occur on posedge clock.

Parameters:
- XLEN, 32, data width of each register.
- NREG, 32, number of registers. Power of two, >= 2. AW = clog2(NREG).
- NRD, 2, number of read ports, 1..4.
- NWR, 2, number of write ports, 1..3.
- ZERO_REG, 1, when 1 register 0 is hardwired to zero and is never busy.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  reset, synchronous, active-high.
- ready  out  1  high once the clear sweep has finished.
- rd_sel  in  NRD*AW  read addresses; port i uses slice i.
- rd_data  out  NRD*XLEN  read data; combinational.
- rd_busy  out  NRD  operand not yet available.
- wr_en  in  NWR  write enables.
- wr_sel  in  NWR*AW  write addresses.
- wr_data  in  NWR*XLEN  write data.
- issue_en  in  1  marks a register as having a pending producer.
- issue_sel  in  AW  destination register of the issued instruction.
- busy_vec  out  NREG  registered scoreboard state.
- par_err  out  NRD  read parity error (REGFILE_PARITY_EN only).

Behaviour:
- FSM states: INIT, RUN.
- Reset (sampled at posedge): state <= INIT, cnt <= 0, busy_vec <= 0, ready <= 0. Reset takes priority over everything, including mid-sweep; a mid-sweep reset restarts the sweep from cnt = 0.
- INIT:
  - Each cycle reg[cnt] <= 0, cnt <= cnt + 1.
  - When cnt == NREG-1 is written, state <= RUN and ready <= 1 in the same edge.
  - ready rises exactly NREG cycles after reset deasserts.
  - wr_en and issue_en are ignored. rd_data forced to 0, rd_busy forced to 1, par_err forced to 0.
- RUN, writes:
  - For each port j with wr_en[j] set and sel != 0 (when ZERO_REG), reg[wr_sel[j]] <= wr_data[j].
  - Two ports writing the same register: the highest port index wins.
- RUN, reads:
  - If rd_sel[i] matches any enabled, non-dropped write this cycle, rd_data[i] returns that port's wr_data (highest index wins). Otherwise rd_data[i] returns the stored value.
  - Register 0 with ZERO_REG=1 always reads 0.
- Scoreboard:
  - Any accepted write to register r clears busy[r] at the next edge.
  - issue_en sets busy[issue_sel] at the next edge.
  - If issue and write target the same register in the same cycle, busy stays set (the new producer wins).
  - issue to register 0 is ignored when ZERO_REG=1.
- rd_busy[i] = busy[rd_sel[i]] AND NOT (same-cycle write hit on rd_sel[i]). It is 0 for register 0 when ZERO_REG=1.
- busy_vec is a direct register output.
- No wrap-around: cnt is only used during INIT and holds its value in RUN.

Optional Feature:
- Macro REGFILE_PARITY_EN.
- Defined:
  - Each entry stores XLEN+1 bits; the extra bit is even parity of the data, computed at write.
  - On read, par_err[i] = 1 when stored parity mismatches the stored data.
  - Bypassed reads and register 0 never flag.
  - The sweep writes parity 0.
- Not defined: no extra storage, par_err tied to 0.

Decomposition:
- Package regfile_pkg:
  - FSM state enum (INIT, RUN).
  - clog2 constant function.
  - Default XLEN/NREG constants.
  - Parity helper function.
- One sub-module, regfile_scoreboard:
  - Contains the busy vector, the issue/clear priority logic and rd_busy generation.
  - Parameters: NREG, NRD, NWR, ZERO_REG.
- The storage array, sweep FSM and bypass muxes stay in the top.

Test Plan:
- Sweep: preload garbage, pulse reset 1 cycle, NREG=32 → ready=0 for 32 cycles then 1; reading all registers returns 0; a write issued during INIT is not retained.
- Bypass: write r5=0xDEADBEEF on port 0 while rd_sel[0]=5 → rd_data[0]=0xDEADBEEF the same cycle and on every later cycle.
- Write conflict: port0 r7=0x1111 and port1 r7=0x2222 in the same cycle → bypass and stored value both 0x2222.
- Zero register: write r0=0xFFFF_FFFF and issue r0 → rd_data=0, busy_vec[0]=0, rd_busy=0.
- Scoreboard:
  - issue r3 → busy_vec[3]=1 next cycle.
  - Read r3 → rd_busy=1.
  - Write r3 → rd_busy=0 that cycle; busy_vec[3]=0 next cycle.
  - Simultaneous issue and write of r3 → busy stays 1.
- Mid-sweep reset and parity: assert reset at cnt=10 → ready rises 32 cycles after the second deassert. With REGFILE_PARITY_EN, force-flip a stored bit of r9 → par_err=1 on that read port.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file with scoreboard.
package regfile_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } rf_state_e;

  localparam int unsigned XLEN_DEFAULT = 32;
  localparam int unsigned NREG_DEFAULT = 32;
  localparam int unsigned PAR_MAXW     = 256;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

  // Even parity bit; callers zero-extend, which leaves the parity unchanged.
  function automatic logic even_parity(input logic [PAR_MAXW-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy tracking: issue sets, accepted writes clear, issue wins ties.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned NREG     = NREG_DEFAULT,
  parameter int unsigned NRD      = 2,
  parameter int unsigned NWR      = 2,
  parameter int unsigned ZERO_REG = 1,
  localparam int unsigned AW      = clog2(NREG)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              run,
  input  logic [NWR-1:0]    wr_ok,
  input  logic [NWR*AW-1:0] wr_sel,
  input  logic              issue_en,
  input  logic [AW-1:0]     issue_sel,
  input  logic [NRD*AW-1:0] rd_sel,
  output logic [NRD-1:0]    rd_busy,
  output logic [NREG-1:0]   busy_vec
);

  logic [NREG-1:0] clr;
  logic [NREG-1:0] set;

  always_comb begin
    clr = '0;
    set = '0;
    for (int unsigned j = 0; j < NWR; j++)
      if (wr_ok[j]) clr[wr_sel[j*AW +: AW]] = 1'b1;
    if (run && issue_en && !(ZERO_REG != 0 && issue_sel == '0))
      set[issue_sel] = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) busy_vec <= '0;
    else       busy_vec <= (busy_vec & ~clr) | set;
  end

  always_comb begin
    logic [AW-1:0] sel;
    logic          hit;
    rd_busy = '0;
    sel     = '0;
    hit     = 1'b0;
    for (int unsigned i = 0; i < NRD; i++) begin
      sel = rd_sel[i*AW +: AW];
      hit = 1'b0;
      for (int unsigned j = 0; j < NWR; j++)
        if (wr_ok[j] && wr_sel[j*AW +: AW] == sel) hit = 1'b1;
      if (!run)                                rd_busy[i] = 1'b1;
      else if (ZERO_REG != 0 && sel == '0)     rd_busy[i] = 1'b0;
      else                                     rd_busy[i] = busy_vec[sel] & ~hit;
    end
  end

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port register file with write-to-read bypass, busy scoreboard and
// post-reset clear sweep. Optional stored parity under REGFILE_PARITY_EN.
module regfile_mp_sb
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN     = XLEN_DEFAULT,
  parameter int unsigned NREG     = NREG_DEFAULT,
  parameter int unsigned NRD      = 2,
  parameter int unsigned NWR      = 2,
  parameter int unsigned ZERO_REG = 1,
  localparam int unsigned AW      = clog2(NREG)
) (
  input  logic                clock,
  input  logic                reset,
  output logic                ready,
  input  logic [NRD*AW-1:0]   rd_sel,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_sel,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic                issue_en,
  input  logic [AW-1:0]       issue_sel,
  output logic [NREG-1:0]     busy_vec,
  output logic [NRD-1:0]      par_err
);

`ifdef REGFILE_PARITY_EN
  localparam int unsigned SW = XLEN + 1;
`else
  localparam int unsigned SW = XLEN;
`endif

  rf_state_e      state;
  logic [AW-1:0]  cnt;
  logic           run;
  logic [SW-1:0]  mem [NREG];
  logic [AW-1:0]  rsel  [NRD];
  logic [AW-1:0]  wsel  [NWR];
  logic [XLEN-1:0] wdat [NWR];
  logic [SW-1:0]  wentry [NWR];
  logic [NWR-1:0] wr_ok;

  assign run = (state == RUN);

  always_comb begin
    for (int unsigned i = 0; i < NRD; i++) rsel[i] = rd_sel[i*AW +: AW];
    for (int unsigned j = 0; j < NWR; j++) begin
      wsel[j]  = wr_sel[j*AW +: AW];
      wdat[j]  = wr_data[j*XLEN +: XLEN];
`ifdef REGFILE_PARITY_EN
      wentry[j] = {even_parity(PAR_MAXW'(wdat[j])), wdat[j]};
`else
      wentry[j] = wdat[j];
`endif
      wr_ok[j] = run && wr_en[j] && !(ZERO_REG != 0 && wsel[j] == '0);
    end
  end

  // cnt parks on NREG-1 once the sweep ends instead of wrapping.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= INIT;
      cnt   <= '0;
      ready <= 1'b0;
    end else if (state == INIT) begin
      if (cnt == AW'(NREG - 1)) begin
        state <= RUN;
        ready <= 1'b1;
      end else begin
        cnt <= cnt + AW'(1);
      end
    end
  end

  // Ascending port loop: the highest-index writer to a register lands last.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (state == INIT) begin
        mem[cnt] <= '0;
      end else begin
        for (int unsigned j = 0; j < NWR; j++)
          if (wr_ok[j]) mem[wsel[j]] <= wentry[j];
      end
    end
  end

  always_comb begin
    rd_data = '0;
    for (int unsigned i = 0; i < NRD; i++) begin
      rd_data[i*XLEN +: XLEN] = mem[rsel[i]][XLEN-1:0];
      for (int unsigned j = 0; j < NWR; j++)
        if (wr_ok[j] && wsel[j] == rsel[i]) rd_data[i*XLEN +: XLEN] = wdat[j];
      if (!run || (ZERO_REG != 0 && rsel[i] == '0)) rd_data[i*XLEN +: XLEN] = '0;
    end
  end

`ifdef REGFILE_PARITY_EN
  always_comb begin
    logic hit;
    par_err = '0;
    hit     = 1'b0;
    for (int unsigned i = 0; i < NRD; i++) begin
      hit = 1'b0;
      for (int unsigned j = 0; j < NWR; j++)
        if (wr_ok[j] && wsel[j] == rsel[i]) hit = 1'b1;
      par_err[i] = run && !hit && !(ZERO_REG != 0 && rsel[i] == '0) &&
                   (mem[rsel[i]][XLEN] != even_parity(PAR_MAXW'(mem[rsel[i]][XLEN-1:0])));
    end
  end
`else
  assign par_err = '0;
`endif

  regfile_scoreboard #(
    .NREG     (NREG),
    .NRD      (NRD),
    .NWR      (NWR),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clock     (clock),
    .reset     (reset),
    .run       (run),
    .wr_ok     (wr_ok),
    .wr_sel    (wr_sel),
    .issue_en  (issue_en),
    .issue_sel (issue_sel),
    .rd_sel    (rd_sel),
    .rd_busy   (rd_busy),
    .busy_vec  (busy_vec)
  );

endmodule
